// File: rtl/spi_command_master.sv
// SPI mode-0 command master: frames opcode plus argument/payload bytes MSB-first
// and captures the status byte returned during a GET_STATUS dummy byte.
module spi_command_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        i_master_clk,
  input  logic        i_reset_n,
  output logic        o_spi_cs_n,
  output logic        o_spi_clk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso,
  input  logic [2:0]  i_cmd,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_mode,
  input  logic [18:0] i_address,
  input  logic [7:0]  i_payload_data,
  input  logic        i_payload_valid,
  input  logic        i_payload_last,
  output logic        o_payload_ready,
  output logic [7:0]  o_status_data,
  output logic        o_status_valid,
  output logic        o_cmd_error,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOW, S_HIGH, S_HOLD, S_GAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [1:0]  r_idx;
  logic [2:0]  r_cmd;
  logic [1:0]  r_mode;
  logic [18:0] r_addr;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx;
  logic        r_last;
  logic        r_cs_n;
  logic        r_sck;
  logic        r_mosi;
  logic        r_cmd_ready;
  logic        r_pay_rdy;
  logic [7:0]  r_status;
  logic        r_status_valid;
  logic        r_cmd_error;
  logic        r_busy;

  logic       w_is_pay;
  logic       w_need_pay;
  logic       w_load_go;
  logic       w_div_end;
  logic       w_gap_end;
  logic       w_more;
  logic [7:0] w_byte;

  assign w_is_pay   = (r_cmd == 3'd1) || (r_cmd == 3'd2);
  assign w_need_pay = w_is_pay && (r_idx != 2'd0);
  assign w_load_go  = !w_need_pay || (r_pay_rdy && i_payload_valid);
  assign w_div_end  = r_cnt == 16'(CLK_DIV - 1);
  assign w_gap_end  = r_cnt == 16'(CS_GAP - 1);

  // r_idx is the byte just sent; payload index saturates at 3
  always_comb begin
    w_more = 1'b0;
    if (w_is_pay)
      w_more = (r_idx == 2'd0) || !r_last;
    else if (r_cmd == 3'd3)
      w_more = r_idx != 2'd3;
    else
      w_more = r_idx == 2'd0;
  end

  always_comb begin
    w_byte = 8'h00;
    if (r_idx == 2'd0)
      w_byte = {5'b0, r_cmd};
    else if (w_is_pay)
      w_byte = i_payload_data;
    else if (r_cmd == 3'd4)
      w_byte = {6'b0, r_mode};
    else if (r_cmd == 3'd3) begin
      case (r_idx)
        2'd1:    w_byte = {5'b0, r_addr[18:16]};
        2'd2:    w_byte = r_addr[15:8];
        default: w_byte = r_addr[7:0];
      endcase
    end
  end

  always_ff @(posedge i_master_clk) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 16'd0;
      r_bit          <= 3'd7;
      r_idx          <= 2'd0;
      r_cmd          <= 3'd0;
      r_mode         <= 2'd0;
      r_addr         <= 19'd0;
      r_shift        <= 8'h00;
      r_rx           <= 8'h00;
      r_last         <= 1'b0;
      r_cs_n         <= 1'b1;
      r_sck          <= 1'b0;
      r_mosi         <= 1'b0;
      r_cmd_ready    <= 1'b1;
      r_pay_rdy      <= 1'b0;
      r_status       <= 8'h00;
      r_status_valid <= 1'b0;
      r_cmd_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_status_valid <= 1'b0;
      r_cmd_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd > 3'd4) begin
              r_cmd_error <= 1'b1;
            end else begin
              r_cmd       <= i_cmd;
              r_mode      <= i_mode;
              r_addr      <= i_address;
              r_idx       <= 2'd0;
              r_cs_n      <= 1'b0;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_load_go) begin
            r_pay_rdy <= 1'b0;
            r_shift   <= w_byte;
            r_mosi    <= w_byte[7];
            r_bit     <= 3'd7;
            r_cnt     <= 16'd0;
            r_state   <= S_LOW;
            if (w_need_pay)
              r_last <= i_payload_last;
          end
        end
        S_LOW: begin
          if (w_div_end) begin
            r_cnt   <= 16'd0;
            r_sck   <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == 16'd0)
            r_rx <= {r_rx[6:0], i_spi_miso};
          if (w_div_end) begin
            r_cnt <= 16'd0;
            r_sck <= 1'b0;
            if (r_bit == 3'd0) begin
              if (r_idx != 2'd3)
                r_idx <= r_idx + 2'd1;
              if (w_more) begin
                r_state   <= S_LOAD;
                r_pay_rdy <= w_is_pay;
              end else begin
                r_state <= S_HOLD;
                if (r_cmd == 3'd0) begin
                  r_status       <= r_rx;
                  r_status_valid <= 1'b1;
                end
              end
            end else begin
              r_bit   <= r_bit - 3'd1;
              r_mosi  <= r_shift[r_bit - 3'd1];
              r_state <= S_LOW;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_cnt   <= 16'd0;
            r_cs_n  <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_spi_cs_n      = r_cs_n;
  assign o_spi_clk       = r_sck;
  assign o_spi_mosi      = r_mosi;
  assign o_cmd_ready     = r_cmd_ready;
  assign o_payload_ready = r_pay_rdy;
  assign o_status_data   = r_status;
  assign o_status_valid  = r_status_valid;
  assign o_cmd_error     = r_cmd_error;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_spi_command_master.sv
// Directed bench for spi_command_master with a mode-0 slave model
// and a negedge monitor for frame bits, CS timing and strobes.
module tb_spi_command_master;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        o_spi_cs_n;
  logic        o_spi_clk;
  logic        o_spi_mosi;
  logic        i_spi_miso;
  logic [2:0]  i_cmd;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_mode;
  logic [18:0] i_address;
  logic [7:0]  i_payload_data;
  logic        i_payload_valid;
  logic        i_payload_last;
  logic        o_payload_ready;
  logic [7:0]  o_status_data;
  logic        o_status_valid;
  logic        o_cmd_error;
  logic        o_busy;

  always #5 clk = ~clk;

  spi_command_master #(.CLK_DIV(4), .CS_GAP(4)) dut (
    .i_master_clk    (clk),
    .i_reset_n       (i_reset_n),
    .o_spi_cs_n      (o_spi_cs_n),
    .o_spi_clk       (o_spi_clk),
    .o_spi_mosi      (o_spi_mosi),
    .i_spi_miso      (i_spi_miso),
    .i_cmd           (i_cmd),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_mode          (i_mode),
    .i_address       (i_address),
    .i_payload_data  (i_payload_data),
    .i_payload_valid (i_payload_valid),
    .i_payload_last  (i_payload_last),
    .o_payload_ready (o_payload_ready),
    .o_status_data   (o_status_data),
    .o_status_valid  (o_status_valid),
    .o_cmd_error     (o_cmd_error),
    .o_busy          (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave model: shifts slave_word out MSB-first, advancing on SCK fall
  logic [15:0] slave_word = 16'h0000;
  int          sidx = 0;
  assign i_spi_miso = (sidx < 16) ? slave_word[15 - sidx] : 1'b0;

  logic        prev_sck  = 1'b0;
  logic        prev_cs   = 1'b1;
  logic        prev_mosi = 1'b0;
  logic [63:0] mosi_sh   = 64'd0;
  int rises = 0, unstable = 0, falls = 0;
  int cs_run = 0, cs_len = 0, gap_run = 0;
  int sv_cnt = 0, err_cnt = 0, hs_cnt = 0, bad_sck = 0;

  always @(negedge clk) begin
    prev_sck  <= o_spi_clk;
    prev_cs   <= o_spi_cs_n;
    prev_mosi <= o_spi_mosi;
    if (!o_spi_cs_n && prev_cs) begin
      cs_run <= 1;
      sidx   <= 0;
      falls  <= falls + 1;
    end else if (!o_spi_cs_n) begin
      cs_run <= cs_run + 1;
    end
    if (o_spi_cs_n && !prev_cs) begin
      cs_len  <= cs_run;
      gap_run <= o_cmd_ready ? 0 : 1;
    end else if (o_spi_cs_n && !o_cmd_ready && o_busy) begin
      gap_run <= gap_run + 1;
    end
    if (o_spi_clk && !prev_sck) begin
      rises   <= rises + 1;
      mosi_sh <= {mosi_sh[62:0], o_spi_mosi};
      if (o_spi_mosi != prev_mosi)
        unstable <= unstable + 1;
    end
    if (!o_spi_clk && prev_sck)
      sidx <= sidx + 1;
    if (o_status_valid)
      sv_cnt <= sv_cnt + 1;
    if (o_cmd_error)
      err_cnt <= err_cnt + 1;
    if (o_payload_ready && i_payload_valid)
      hs_cnt <= hs_cnt + 1;
    if (o_payload_ready && o_spi_clk)
      bad_sck <= bad_sck + 1;
  end

  task automatic send(input logic [2:0] c, input logic [1:0] m,
                      input logic [18:0] a);
    i_cmd       = c;
    i_mode      = m;
    i_address   = a;
    i_cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (o_cmd_ready)
        break;
      @(negedge clk);
    end
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(o_cmd_ready && !o_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000)
      chk("idle_timeout", 64'(k), 64'd0);
    #2;
  endtask

  task automatic pay_byte(input logic [7:0] d, input logic last);
    int k;
    i_payload_data  = d;
    i_payload_last  = last;
    i_payload_valid = 1'b1;
    k = 0;
    while (!o_payload_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000)
      chk("pay_timeout", 64'(k), 64'd0);
    @(negedge clk);
    i_payload_valid = 1'b0;
  endtask

  task automatic wait_pay_rdy();
    int k;
    k = 0;
    while (!o_payload_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000)
      chk("payrdy_timeout", 64'(k), 64'd0);
  endtask

  int r0, s0, e0, f0, h0, b0, u0;

  initial begin
    i_reset_n       = 1'b0;
    i_cmd           = 3'd0;
    i_cmd_valid     = 1'b0;
    i_mode          = 2'd0;
    i_address       = 19'd0;
    i_payload_data  = 8'h00;
    i_payload_valid = 1'b0;
    i_payload_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(o_spi_cs_n), 64'd1);
    chk("rst_sck", 64'(o_spi_clk), 64'd0);
    chk("rst_mosi", 64'(o_spi_mosi), 64'd0);
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_outs", 64'({o_payload_ready, o_status_valid,
                         o_cmd_error, o_busy, o_status_data}), 64'd0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // GET_STATUS, slave returns 0xA5 in the dummy byte
    slave_word = 16'h00A5;
    r0 = rises; s0 = sv_cnt;
    send(3'd0, 2'd0, 19'd0);
    chk("gs_cs_fall", 64'(o_spi_cs_n), 64'd0);
    chk("gs_busy", 64'(o_busy), 64'd1);
    wait_idle();
    chk("gs_mosi", mosi_sh[15:0], 64'h0000);
    chk("gs_rises", 64'(rises - r0), 64'd16);
    chk("gs_status", 64'(o_status_data), 64'hA5);
    chk("gs_sv_pulses", 64'(sv_cnt - s0), 64'd1);
    chk("gs_cs_len", 64'(cs_len), 64'd134);

    // VIDEO_FRAME
    r0 = rises; u0 = unstable;
    send(3'd3, 2'd0, 19'h5ABCD);
    wait_idle();
    chk("vf_mosi", mosi_sh[31:0], 64'h0305ABCD);
    chk("vf_rises", 64'(rises - r0), 64'd32);
    chk("vf_mosi_stable", 64'(unstable - u0), 64'd0);
    chk("vf_cs_len", 64'(cs_len), 64'd264);

    // SET_MODE and CS gap
    send(3'd4, 2'd2, 19'd0);
    wait_idle();
    chk("sm_mosi", mosi_sh[15:0], 64'h0402);
    chk("sm_gap", 64'(gap_run), 64'd4);
    chk("sm_cs_len", 64'(cs_len), 64'd134);

    // STORE_DATA with a 10-cycle stall before the second payload byte
    r0 = rises; h0 = hs_cnt; b0 = bad_sck;
    fork
      begin
        send(3'd2, 2'd0, 19'd0);
        wait_idle();
      end
      begin
        pay_byte(8'h11, 1'b0);
        i_payload_last = 1'b1;
        wait_pay_rdy();
        repeat (10) @(negedge clk);
        pay_byte(8'h22, 1'b0);
        pay_byte(8'h33, 1'b1);
        i_payload_last = 1'b0;
      end
    join
    chk("sd_mosi", mosi_sh[31:0], 64'h02112233);
    chk("sd_rises", 64'(rises - r0), 64'd32);
    chk("sd_handshakes", 64'(hs_cnt - h0), 64'd3);
    chk("sd_sck_stall", 64'(bad_sck - b0), 64'd0);
    chk("sd_cs_len", 64'(cs_len), 64'd274);

    // illegal opcode
    e0 = err_cnt; f0 = falls;
    i_cmd = 3'd6;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    chk("ill_err", 64'(o_cmd_error), 64'd1);
    chk("ill_ready", 64'(o_cmd_ready), 64'd1);
    chk("ill_cs", 64'(o_spi_cs_n), 64'd1);
    @(negedge clk);
    chk("ill_err_clr", 64'(o_cmd_error), 64'd0);
    repeat (5) @(negedge clk);
    chk("ill_no_cs", 64'(falls - f0), 64'd0);
    chk("ill_err_cnt", 64'(err_cnt - e0), 64'd1);

    // reset during byte 2 of FILL_QUEUE
    r0 = rises; s0 = sv_cnt;
    fork
      send(3'd1, 2'd0, 19'd0);
      pay_byte(8'hDE, 1'b0);
    join
    for (int i = 0; i < 3000; i++) begin
      if (rises - r0 >= 11)
        break;
      @(negedge clk);
    end
    chk("fq_progress", 64'(rises - r0 >= 11), 64'd1);
    i_reset_n = 1'b0;
    @(negedge clk);
    chk("rr_cs_n", 64'(o_spi_cs_n), 64'd1);
    chk("rr_sck", 64'(o_spi_clk), 64'd0);
    chk("rr_ready", 64'(o_cmd_ready), 64'd1);
    chk("rr_status", 64'(o_status_data), 64'h00);
    i_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_no_sv", 64'(sv_cnt - s0), 64'd0);

    slave_word = 16'h003C;
    s0 = sv_cnt;
    send(3'd0, 2'd0, 19'd0);
    wait_idle();
    chk("gs2_status", 64'(o_status_data), 64'h3C);
    chk("gs2_sv", 64'(sv_cnt - s0), 64'd1);
    chk("gs2_cs_len", 64'(cs_len), 64'd134);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
